rxc: RTL

Receive-side controller for alink; the counterpart of the TX controller. It selects one PHY holding a completed receive frame using round-robin arbitration among masked PHYs. It drains that frame into the shared RX FIFO behind a one-word header that carries the PHY index. A per-frame watchdog aborts a stalled PHY, and frame and abort counters are exposed to the slave register block.

---
 rtl/rxc_pkg.sv | 25 ++
 rtl/rr_arb.sv | 34 +++
 rtl/rxc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rxc_pkg.sv
// Shared definitions for the alink receive controller: state encodings,
// header magic, default sizing and saturating counter helpers.
package rxc_pkg;

   typedef enum logic [1:0] {
      RX_IDLE = 2'b00,
      RX_HDR  = 2'b01,
      RX_RECV = 2'b10,
      RX_BAD  = 2'b11
   } rx_state_e;

   localparam int          PHY_NUM_DEF   = 5;
   localparam int          MAX_WORDS_DEF = 8;
   localparam int          WDOG_CYC_DEF  = 255;
   localparam logic [15:0] HDR_MAGIC     = 16'hA11C;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: grants the first requester found
// scanning upward from last+1 and wrapping at N.
module rr_arb #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found_s;
   logic [IW-1:0] pos_s;

   // priority scan starting just above the previous winner
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found_s = 1'b0;
      pos_s   = '0;
      for (int k = 1; k <= N; k++) begin
         pos_s = IW'((int'(last) + k) % N);
         if (!found_s && req[pos_s]) begin
            found_s    = 1'b1;
            gnt[pos_s] = 1'b1;
            idx        = pos_s;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rxc.sv
// alink receive controller: arbitrates among PHYs holding a frame, writes a
// header plus payload into the RX FIFO, with watchdog and frame counters.
module rxc
   import rxc_pkg::*;
#(
   parameter int PHY_NUM   = PHY_NUM_DEF,
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int WDOG_CYC  = WDOG_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reg_flush,
   input  logic [PHY_NUM-1:0] reg_mask,
   input  logic [PHY_NUM-1:0] rx_phy_vld,
   output logic               rx_phy_start,
   output logic [PHY_NUM-1:0] rx_phy_sel,
   input  logic               rx_phy_wr,
   input  logic [31:0]        rx_phy_dat,
   input  logic               rx_phy_done,
   input  logic               rx_fifo_room,
   output logic               rx_fifo_wr,
   output logic [31:0]        rx_fifo_dat,
   output logic [1:0]         cur_state,
   output logic [31:0]        reg_rx_cnt,
   output logic [15:0]        reg_abort_cnt
);

   localparam int IW  = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;
   localparam int WCW = $clog2(MAX_WORDS + 1);
   localparam int WDW = $clog2(WDOG_CYC + 1);

   rx_state_e          state_q, state_d;
   logic [PHY_NUM-1:0] sel_q, sel_d;
   logic [IW-1:0]      last_q, last_d;
   logic               fifo_wr_q, fifo_wr_d;
   logic [31:0]        fifo_dat_q, fifo_dat_d;
   logic [WCW-1:0]     wcnt_q, wcnt_d;
   logic               ovf_q, ovf_d;
   logic [WDW-1:0]     wdog_q, wdog_d;
   logic [31:0]        rx_cnt_q, rx_cnt_d;
   logic [15:0]        abort_cnt_q, abort_cnt_d;

   logic [PHY_NUM-1:0] elig_s;
   logic [PHY_NUM-1:0] gnt_s;
   logic [IW-1:0]      idx_s;

   assign elig_s = rx_phy_vld & reg_mask;

   rr_arb #(.N(PHY_NUM), .IW(IW)) u_arb (
      .req  (elig_s),
      .last (last_q),
      .gnt  (gnt_s),
      .idx  (idx_s)
   );

   // next-state, datapath and counter update
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      fifo_wr_d   = 1'b0;
      fifo_dat_d  = fifo_dat_q;
      wcnt_d      = wcnt_q;
      ovf_d       = ovf_q;
      wdog_d      = wdog_q;
      rx_cnt_d    = rx_cnt_q;
      abort_cnt_d = abort_cnt_q;
      if (reg_flush) begin
         state_d = RX_IDLE;
         sel_d   = '0;
         last_d  = IW'(PHY_NUM - 1);
         wcnt_d  = '0;
         ovf_d   = 1'b0;
         wdog_d  = '0;
      end else begin
         case (state_q)
            RX_IDLE: begin
               if ((|elig_s) && rx_fifo_room) begin
                  state_d = RX_HDR;
                  sel_d   = gnt_s;
                  last_d  = idx_s;
                  wcnt_d  = '0;
                  ovf_d   = 1'b0;
                  wdog_d  = '0;
               end else begin
                  state_d = RX_IDLE;
               end
            end
            RX_HDR: begin
               fifo_wr_d  = 1'b1;
               fifo_dat_d = {HDR_MAGIC, 16'(last_q)};
               wdog_d     = '0;
               state_d    = RX_RECV;
            end
            RX_RECV: begin
               if (rx_phy_wr) begin
                  wdog_d = '0;
                  if (wcnt_q < WCW'(MAX_WORDS)) begin
                     fifo_wr_d  = 1'b1;
                     fifo_dat_d = rx_phy_dat;
                     wcnt_d     = wcnt_q + WCW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  wdog_d = wdog_q + WDW'(1);
               end
               // an overflow word arriving with done still counts as an abort
               if (rx_phy_done) begin
                  state_d = RX_IDLE;
                  sel_d   = '0;
                  if (ovf_d) begin
                     abort_cnt_d = sat_inc16(abort_cnt_q);
                  end else begin
                     rx_cnt_d = sat_inc32(rx_cnt_q);
                  end
               end else if (!rx_phy_wr && (wdog_q == WDW'(WDOG_CYC - 1))) begin
                  state_d     = RX_IDLE;
                  sel_d       = '0;
                  abort_cnt_d = sat_inc16(abort_cnt_q);
               end else begin
                  state_d = RX_RECV;
               end
            end
            default: begin
               state_d = RX_IDLE;
               sel_d   = '0;
            end
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RX_IDLE;
         sel_q       <= '0;
         last_q      <= IW'(PHY_NUM - 1);
         fifo_wr_q   <= 1'b0;
         fifo_dat_q  <= 32'd0;
         wcnt_q      <= '0;
         ovf_q       <= 1'b0;
         wdog_q      <= '0;
         rx_cnt_q    <= 32'd0;
         abort_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_dat_q  <= fifo_dat_d;
         wcnt_q      <= wcnt_d;
         ovf_q       <= ovf_d;
         wdog_q      <= wdog_d;
         rx_cnt_q    <= rx_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign rx_phy_start  = (state_q == RX_HDR);
   assign rx_phy_sel    = sel_q;
   assign rx_fifo_wr    = fifo_wr_q;
   assign rx_fifo_dat   = fifo_dat_q;
   assign cur_state     = state_q;
   assign reg_rx_cnt    = rx_cnt_q;
   assign reg_abort_cnt = abort_cnt_q;

endmodule
